// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer: runs one load/store per request over a
// req/ack memory port, stalls the pipeline while busy, and formats load results.
module dmem_access_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              stall,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              misalign,
    output logic              timeout,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       stall_cycles
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [2:0]        lat_funct3;
    logic              lat_we;
    logic [7:0]        wait_cnt;
    logic              timeout_pending;

    logic              request;
    logic              aligned;
    logic              accept;
    logic [3:0]        be_calc;
    logic [DATA_W-1:0] wdata_calc;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [DATA_W-1:0] load_fmt;

    assign request = mem_read | mem_write;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        aligned = 1'b0;
        unique case (funct3[1:0])
            SZ_B:    aligned = 1'b1;
            SZ_H:    aligned = ~addr[0];
            SZ_W:    aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    // Reset gating keeps stall/misalign low while reset is held with a request present.
    assign accept   = (state == S_IDLE) && request && aligned && !reset;
    assign misalign = (state == S_IDLE) && request && !aligned && !reset;
    assign stall    = accept || (state == S_ISSUE) || (state == S_WAIT);
    assign rd_valid = (state == S_DONE);
    assign timeout  = (state == S_DONE) && timeout_pending;

    always_comb begin
        be_calc    = 4'b0000;
        wdata_calc = lat_wdata;
        unique case (lat_funct3[1:0])
            SZ_B: begin
                be_calc    = 4'b0001 << lat_addr[1:0];
                wdata_calc = {(DATA_W/8){lat_wdata[7:0]}};
            end
            SZ_H: begin
                be_calc    = lat_addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {(DATA_W/16){lat_wdata[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = lat_wdata;
            end
        endcase
    end

    assign mem_req   = (state == S_ISSUE);
    assign mem_we    = mem_req && lat_we;
    assign mem_addr  = mem_req ? lat_addr[ADDR_W-1:2] : '0;
    assign mem_be    = mem_req ? be_calc : 4'b0000;
    assign mem_wdata = mem_req ? wdata_calc : '0;

    always_comb begin
        sel_byte = mem_rdata[{lat_addr[1:0], 3'b000} +: 8];
        sel_half = lat_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (lat_funct3[1:0])
            SZ_B:    load_fmt = {{(DATA_W-8){sel_byte[7] & ~lat_funct3[2]}}, sel_byte};
            SZ_H:    load_fmt = {{(DATA_W-16){sel_half[15] & ~lat_funct3[2]}}, sel_half};
            default: load_fmt = mem_rdata;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            lat_addr        <= '0;
            lat_wdata       <= '0;
            lat_funct3      <= '0;
            lat_we          <= 1'b0;
            wait_cnt        <= '0;
            timeout_pending <= 1'b0;
            rd_data         <= '0;
            stall_cycles    <= '0;
        end else begin
            if (stall && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;

            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_addr   <= addr;
                        lat_wdata  <= wr_data;
                        lat_funct3 <= funct3;
                        lat_we     <= mem_write;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        if (!lat_we)
                            rd_data <= load_fmt;
                        state <= S_DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        rd_data         <= '0;
                        timeout_pending <= 1'b1;
                        state           <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    timeout_pending <= 1'b0;
                    state           <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed scoreboard bench for dmem_access_ctrl: expected transactions are queued
// when a request is driven and compared when the memory port and rd_valid respond.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic        stall, rd_valid, misalign, timeout;
    logic [31:0] rd_data;
    logic        mem_req, mem_we;
    logic [6:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [31:0] stall_cycles;

    typedef struct {
        logic        we;
        logic [6:0]  maddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        to;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_stall = 0;

    dmem_access_ctrl #(.DATA_W(32), .ADDR_W(9), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .addr(addr), .wr_data(wr_data),
        .stall(stall), .rd_data(rd_data), .rd_valid(rd_valid),
        .misalign(misalign), .timeout(timeout),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drop_inputs();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        funct3    = 3'b000;
        addr      = '0;
        wr_data   = '0;
    endtask

    // ack_wait: WAIT cycles before the ack (0 = first WAIT cycle), negative = never acked.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [8:0] a, input logic [31:0] wd,
                             input int ack_wait, input logic [31:0] rdata,
                             input logic [6:0] e_addr, input logic [3:0] e_be,
                             input logic [31:0] e_wdata, input logic [31:0] e_rd,
                             input logic e_to, input int lat);
        exp_t e;
        int   req_cyc;
        int   req_cnt;
        bit   done;
        e = '{we: wr, maddr: e_addr, be: e_be, wdata: e_wdata, rd: e_rd, to: e_to, lat: lat};
        sb.push_back(e);
        exp_stall = exp_stall + 32'(lat);
        req_cyc = -100;
        req_cnt = 0;
        done    = 1'b0;
        @(posedge clk); #1;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wr_data   = wd;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            mem_ack   = (ack_wait >= 0) && (cyc == req_cyc + 1 + ack_wait);
            mem_rdata = mem_ack ? rdata : 32'hA5A5_5A5A;
            #1;
            check($sformatf("stall_c%0d", cyc), {31'b0, stall}, {31'b0, cyc < lat});
            if (mem_req) begin
                req_cyc = cyc;
                req_cnt++;
                check("req_cycle", req_cyc, 1);
                check("mem_we", {31'b0, mem_we}, {31'b0, sb[0].we});
                check("mem_addr", {25'b0, mem_addr}, {25'b0, sb[0].maddr});
                check("mem_be", {28'b0, mem_be}, {28'b0, sb[0].be});
                check("mem_wdata", mem_wdata, sb[0].wdata);
            end
            if (rd_valid) begin
                e = sb.pop_front();
                check("rd_data", rd_data, e.rd);
                check("timeout", {31'b0, timeout}, {31'b0, e.to});
                check("valid_cycle", cyc, e.lat);
                done = 1'b1;
            end
            @(posedge clk); #1;
            if (done) begin
                drop_inputs();
                mem_ack = 1'b0;
            end
        end
        if (!done) begin
            check("rd_valid_bound", 0, 1);
            if (sb.size() > 0) void'(sb.pop_front());
            drop_inputs();
            mem_ack = 1'b0;
        end
        check("req_count", req_cnt, 1);
        check("stall_cycles", stall_cycles, exp_stall);
    endtask

    task automatic misalign_case(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [8:0] a);
        @(posedge clk); #1;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wr_data   = 32'h1111_2222;
        #1;
        check("mis_pulse", {31'b0, misalign}, 32'd1);
        check("mis_stall", {31'b0, stall}, 32'd0);
        check("mis_req", {31'b0, mem_req}, 32'd0);
        @(posedge clk); #1;
        drop_inputs();
        #1;
        check("mis_clear", {31'b0, misalign}, 32'd0);
        check("mis_req_after", {31'b0, mem_req}, 32'd0);
        check("mis_stall_after", {31'b0, stall}, 32'd0);
        check("mis_stall_cnt", stall_cycles, exp_stall);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, {31'b0, stall}, 32'd0);
        check({tag, "_rd_valid"}, {31'b0, rd_valid}, 32'd0);
        check({tag, "_misalign"}, {31'b0, misalign}, 32'd0);
        check({tag, "_timeout"}, {31'b0, timeout}, 32'd0);
        check({tag, "_mem_req"}, {31'b0, mem_req}, 32'd0);
        check({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
        check({tag, "_mem_addr"}, {25'b0, mem_addr}, 32'd0);
        check({tag, "_mem_be"}, {28'b0, mem_be}, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_rd_data"}, rd_data, 32'd0);
        check({tag, "_stall_cycles"}, stall_cycles, 32'd0);
    endtask

    initial begin
        drop_inputs();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        reset     = 1'b1;
        #1;
        mem_read = 1'b1;
        funct3   = 3'b010;
        #1;
        check_all_zero("reset");
        drop_inputs();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // LW: minimum latency
        do_access(1, 0, 3'b010, 9'h010, 32'h0, 0, 32'hDEAD_BEEF,
                  7'h04, 4'b1111, 32'h0, 32'hDEAD_BEEF, 0, 3);
        // SB to lane 3, ack in third WAIT cycle; rd_data untouched
        do_access(0, 1, 3'b000, 9'h003, 32'h1234_56AB, 2, 32'hFFFF_FFFF,
                  7'h00, 4'b1000, 32'hABAB_ABAB, 32'hDEAD_BEEF, 0, 5);
        // SH to upper half
        do_access(0, 1, 3'b001, 9'h00A, 32'h7777_BEEF, 1, 32'h0,
                  7'h02, 4'b1100, 32'hBEEF_BEEF, 32'hDEAD_BEEF, 0, 4);
        // LH / LHU / LB load formatting on the same word
        do_access(1, 0, 3'b001, 9'h006, 32'h0, 0, 32'h80F0_1234,
                  7'h01, 4'b1100, 32'h0, 32'hFFFF_80F0, 0, 3);
        do_access(1, 0, 3'b101, 9'h006, 32'h0, 0, 32'h80F0_1234,
                  7'h01, 4'b1100, 32'h0, 32'h0000_80F0, 0, 3);
        do_access(1, 0, 3'b000, 9'h005, 32'h0, 0, 32'h80F0_1234,
                  7'h01, 4'b0010, 32'h0, 32'h0000_0012, 0, 3);
        // LB negative byte, LBU same byte
        do_access(1, 0, 3'b000, 9'h1FF, 32'h0, 0, 32'h9A00_0000,
                  7'h7F, 4'b1000, 32'h0, 32'hFFFF_FF9A, 0, 3);
        do_access(1, 0, 3'b100, 9'h1FF, 32'h0, 0, 32'h9A00_0000,
                  7'h7F, 4'b1000, 32'h0, 32'h0000_009A, 0, 3);

        // Misaligned and illegal-size requests
        misalign_case(1, 0, 3'b010, 9'h002);
        misalign_case(1, 0, 3'b011, 9'h000);
        misalign_case(0, 1, 3'b001, 9'h001);

        // Controller is back in IDLE: a legal access follows immediately
        do_access(1, 0, 3'b010, 9'h008, 32'h0, 0, 32'h0BAD_F00D,
                  7'h02, 4'b1111, 32'h0, 32'h0BAD_F00D, 0, 3);

        // Timeout: 16 WAIT cycles, rd_valid in cycle 18
        do_access(1, 0, 3'b010, 9'h040, 32'h0, -1, 32'h0,
                  7'h10, 4'b1111, 32'h0, 32'h0, 1, 18);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("late_ack_valid", {31'b0, rd_valid}, 32'd0);
            check("late_ack_timeout", {31'b0, timeout}, 32'd0);
            check("late_ack_req", {31'b0, mem_req}, 32'd0);
            check("late_ack_stall", {31'b0, stall}, 32'd0);
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        check("late_ack_rd_data", rd_data, 32'h0);

        // Asynchronous reset mid-WAIT
        do_access(1, 0, 3'b010, 9'h0FC, 32'h0, 1, 32'h1357_2468,
                  7'h3F, 4'b1111, 32'h0, 32'h1357_2468, 0, 4);
        @(posedge clk); #1;
        mem_read = 1'b1;
        funct3   = 3'b010;
        addr     = 9'h0F0;
        repeat (4) @(posedge clk);
        #3;
        check("pre_reset_stall", {31'b0, stall}, 32'd1);
        reset     = 1'b1;
        mem_write = 1'b1;
        #1;
        check_all_zero("midreset");
        exp_stall = 0;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        drop_inputs();
        // Both read and write set: performed as a store
        do_access(1, 1, 3'b010, 9'h020, 32'hCAFE_F00D, 0, 32'h5555_5555,
                  7'h08, 4'b1111, 32'hCAFE_F00D, 32'h0, 0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
